// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA raster generator.
// Defaults describe 640x480 at a 25 MHz pixel tick.
package vga_pkg;

   typedef struct packed {
      logic hs;
      logic vs;
      logic da;
      logic line_start;
      logic frame_start;
   } vga_ctl_t;

   localparam int DEF_WIDTH     = 32'sd640;
   localparam int DEF_HEIGHT    = 32'sd480;
   localparam int DEF_HFRONT    = 32'sd16;
   localparam int DEF_HSYNC     = 32'sd96;
   localparam int DEF_HBACK     = 32'sd48;
   localparam int DEF_VFRONT    = 32'sd10;
   localparam int DEF_VSYNC     = 32'sd2;
   localparam int DEF_VBACK     = 32'sd33;
   localparam int DEF_TILE_LOG2 = 32'sd5;
   localparam int DEF_LAT       = 32'sd1;

   function automatic int calc_total(input int vis, input int front, input int sync, input int back);
      return vis + front + sync + back;
   endfunction

   // Tiles per row, rounding a partial tile at the right edge up.
   function automatic int calc_cols(input int width, input int tile_log2);
      return (width + (32'sd1 <<< tile_log2) - 32'sd1) >>> tile_log2;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-tick input and raster/pin outputs of the VGA timing generator.
interface vga_timing_gen_if #(
   parameter int ADDR_W = 32
);
   logic              en;
   logic [ADDR_W-1:0] vaddr;
   logic              vga_HS;
   logic              vga_VS;
   logic              vga_DA;
   logic [11:0]       px_x;
   logic [11:0]       px_y;
   logic              line_start;
   logic              frame_start;

   modport master (
      input  en,
      output vaddr, vga_HS, vga_VS, vga_DA, px_x, px_y, line_start, frame_start
   );

   modport slave (
      output en,
      input  vaddr, vga_HS, vga_VS, vga_DA, px_x, px_y, line_start, frame_start
   );
endinterface

// File: rtl/vga_delay_line.sv
// En-gated shift register of control bits; the output stage drops its
// strobes on idle ticks so a pulse never outlives the tick that produced it.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     en_i,
   input  vga_ctl_t rst_val_i,
   input  vga_ctl_t d_i,
   output vga_ctl_t q_o
);

   if (DEPTH < 32'sd1) begin : g_bad_depth
      $error("vga_delay_line: DEPTH must be at least 1");
   end

   vga_ctl_t stage_q [DEPTH];
   vga_ctl_t stage_d [DEPTH];
   vga_ctl_t src_s   [DEPTH];

   // Source of each stage: the input for stage 0, the previous stage otherwise.
   always_comb begin
      src_s[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
         src_s[i] = stage_q[i-1];
      end
   end

   // Shift on en; hold otherwise, with the output strobes forced low.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (en_i) begin
            stage_d[i] = src_s[i];
         end else begin
            stage_d[i] = stage_q[i];
         end
      end
      stage_d[DEPTH-1].line_start  = stage_d[DEPTH-1].line_start  & en_i;
      stage_d[DEPTH-1].frame_start = stage_d[DEPTH-1].frame_start & en_i;
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            stage_q[i] <= rst_val_i;
         end else begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: X/Y counters, tile address for the
// video RAM, and sync/blank/strobe bits delayed to meet the returned data.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int          WIDTH     = DEF_WIDTH,
   parameter int          HEIGHT    = DEF_HEIGHT,
   parameter int          HFRONT    = DEF_HFRONT,
   parameter int          HSYNC     = DEF_HSYNC,
   parameter int          HBACK     = DEF_HBACK,
   parameter bit          HPULSEN   = 1'b1,
   parameter int          VFRONT    = DEF_VFRONT,
   parameter int          VSYNC     = DEF_VSYNC,
   parameter int          VBACK     = DEF_VBACK,
   parameter bit          VPULSEN   = 1'b1,
   parameter int          TILE_LOG2 = DEF_TILE_LOG2,
   parameter int          LAT       = DEF_LAT,
   parameter int unsigned BASE      = 32'd0,
   parameter int          ADDR_W    = 32
) (
   input logic              clk,
   input logic              reset,
   vga_timing_gen_if.master bus
);

   localparam int HTOTAL = calc_total(WIDTH, HFRONT, HSYNC, HBACK);
   localparam int VTOTAL = calc_total(HEIGHT, VFRONT, VSYNC, VBACK);
   localparam int COLS   = calc_cols(WIDTH, TILE_LOG2);

   localparam logic [11:0] H_LAST = 12'(HTOTAL - 32'sd1);
   localparam logic [11:0] V_LAST = 12'(VTOTAL - 32'sd1);
   localparam logic [11:0] H_VIS  = 12'(WIDTH);
   localparam logic [11:0] V_VIS  = 12'(HEIGHT);
   localparam logic [11:0] H_SS   = 12'(WIDTH + HFRONT);
   localparam logic [11:0] H_SE   = 12'(WIDTH + HFRONT + HSYNC);
   localparam logic [11:0] V_SS   = 12'(HEIGHT + VFRONT);
   localparam logic [11:0] V_SE   = 12'(HEIGHT + VFRONT + VSYNC);

   localparam vga_ctl_t CTL_IDLE = '{hs: HPULSEN, vs: VPULSEN, da: 1'b0,
                                     line_start: 1'b0, frame_start: 1'b0};

   if (TILE_LOG2 < 32'sd0 || TILE_LOG2 > 32'sd6) begin : g_bad_tile
      $error("vga_timing_gen: TILE_LOG2 must be in 0..6");
   end
   if (LAT < 32'sd0 || LAT > 32'sd4) begin : g_bad_lat
      $error("vga_timing_gen: LAT must be in 0..4");
   end
   if (HFRONT < 32'sd1 || HSYNC < 32'sd1 || HBACK < 32'sd1 ||
       VFRONT < 32'sd1 || VSYNC < 32'sd1 || VBACK < 32'sd1) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be at least 1");
   end
   if (HTOTAL > 32'sd4096 || VTOTAL > 32'sd4096) begin : g_bad_total
      $error("vga_timing_gen: totals must fit the 12-bit counters");
   end

   logic [11:0]       cnt_x_q, cnt_x_d;
   logic [11:0]       cnt_y_q, cnt_y_d;
   logic [11:0]       px_x_q,  px_x_d;
   logic [11:0]       px_y_q,  px_y_d;
   logic [ADDR_W-1:0] vaddr_q, vaddr_d;
   logic [ADDR_W-1:0] row_s, col_s, tile_addr_s;
   logic              x_last_s, y_last_s;
   vga_ctl_t          ctl_raw_s;
   vga_ctl_t          ctl_out_s;

   // Raster counters: X wraps after HTOTAL ticks and carries into Y.
   always_comb begin
      x_last_s = (cnt_x_q == H_LAST);
      y_last_s = (cnt_y_q == V_LAST);
      cnt_x_d  = cnt_x_q;
      cnt_y_d  = cnt_y_q;
      if (bus.en) begin
         if (x_last_s) begin
            cnt_x_d = 12'd0;
            if (y_last_s) begin
               cnt_y_d = 12'd0;
            end else begin
               cnt_y_d = cnt_y_q + 12'd1;
            end
         end else begin
            cnt_x_d = cnt_x_q + 12'd1;
         end
      end else begin
         cnt_x_d = cnt_x_q;
         cnt_y_d = cnt_y_q;
      end
   end

   // Stage 0: position and tile word address, unclamped outside the visible area.
   always_comb begin
      row_s       = ADDR_W'(cnt_y_q >> TILE_LOG2);
      col_s       = ADDR_W'(cnt_x_q >> TILE_LOG2);
      tile_addr_s = ADDR_W'(BASE) + row_s * ADDR_W'(COLS) + col_s;
      if (bus.en) begin
         px_x_d  = cnt_x_q;
         px_y_d  = cnt_y_q;
         vaddr_d = tile_addr_s;
      end else begin
         px_x_d  = px_x_q;
         px_y_d  = px_y_q;
         vaddr_d = vaddr_q;
      end
   end

   // Pin-level control bits for the same raster position, polarity applied.
   always_comb begin
      ctl_raw_s.hs          = ((cnt_x_q >= H_SS) && (cnt_x_q < H_SE)) ^ HPULSEN;
      ctl_raw_s.vs          = ((cnt_y_q >= V_SS) && (cnt_y_q < V_SE)) ^ VPULSEN;
      ctl_raw_s.da          = (cnt_x_q < H_VIS) && (cnt_y_q < V_VIS);
      ctl_raw_s.line_start  = (cnt_x_q == 12'd0);
      ctl_raw_s.frame_start = (cnt_x_q == 12'd0) && (cnt_y_q == 12'd0);
   end

   // Counter and stage-0 registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_x_q <= 12'd0;
         cnt_y_q <= 12'd0;
         px_x_q  <= 12'd0;
         px_y_q  <= 12'd0;
         vaddr_q <= ADDR_W'(BASE);
      end else begin
         cnt_x_q <= cnt_x_d;
         cnt_y_q <= cnt_y_d;
         px_x_q  <= px_x_d;
         px_y_q  <= px_y_d;
         vaddr_q <= vaddr_d;
      end
   end

   // LAT+1 stages so the pins trail vaddr by exactly LAT ticks.
   vga_delay_line #(
      .DEPTH (LAT + 32'sd1)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .en_i      (bus.en),
      .rst_val_i (CTL_IDLE),
      .d_i       (ctl_raw_s),
      .q_o       (ctl_out_s)
   );

   assign bus.vaddr       = vaddr_q;
   assign bus.px_x        = px_x_q;
   assign bus.px_y        = px_y_q;
   assign bus.vga_HS      = ctl_out_s.hs;
   assign bus.vga_VS      = ctl_out_s.vs;
   assign bus.vga_DA      = ctl_out_s.da;
   assign bus.line_start  = ctl_out_s.line_start;
   assign bus.frame_start = ctl_out_s.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a short-frame 640-wide configuration with LAT=2,
// 4-pixel tiles and BASE=0x1000, compared each cycle against a tick-count model.
module tb_vga_timing_gen;

   localparam int W = 640, H = 12, HF = 16, HSY = 96, HB = 48;
   localparam int VF = 2, VSY = 2, VB = 3, T = 2, LAT = 2;
   localparam longint BASE = 64'h1000;
   localparam longint HT = W + HF + HSY + HB;      // 800
   localparam longint VT = H + VF + VSY + VB;      // 19
   localparam longint FR = HT * VT;                // 15200
   localparam longint COLS = (W + (1 << T) - 1) >> T;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.ADDR_W(32)) bus ();

   vga_timing_gen #(
      .WIDTH(W), .HEIGHT(H), .HFRONT(HF), .HSYNC(HSY), .HBACK(HB), .HPULSEN(1'b1),
      .VFRONT(VF), .VSYNC(VSY), .VBACK(VB), .VPULSEN(1'b1),
      .TILE_LOG2(T), .LAT(LAT), .BASE(32'h1000), .ADDR_W(32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model state: pixel ticks since reset, and whether the last edge was a tick.
   longint k = 0;
   bit     last_en = 1'b0;
   bit     check_on = 1'b0;

   int     da_cnt, ls_cnt, fs_cnt, vs_low_cnt, hs_run, last_hs_run, wide_cnt, pin_hit;
   longint cyc, last_ls_cyc, last_gap;
   bit     prev_ls;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      da_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_low_cnt = 0;
      hs_run = 0; last_hs_run = 0; wide_cnt = 0; last_gap = 0;
   endtask

   task automatic step(input bit e, input bit r);
      bus.en = e;
      reset  = r;
      @(posedge clk);
      if (r) begin
         k = 0;
         last_en = 1'b0;
      end else if (e) begin
         k++;
         last_en = 1'b1;
      end else begin
         last_en = 1'b0;
      end
      #1;
   endtask

   task automatic run(input int n, input int mode);
      bit e;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       e = 1'b1;
            1:       e = ((i % 2) == 0);
            default: e = ($urandom_range(0, 3) != 0);
         endcase
         step(e, 1'b0);
      end
   endtask

   longint p, q;
   longint ex, ey, qx, qy, ev;
   bit     ehs, evs, eda, els, efs;

   // Per-cycle compare against the model, plus running statistics.
   always @(negedge clk) begin
      if (check_on) begin
         if (k == 0) begin
            ex = 0; ey = 0;
         end else begin
            p = (k - 1) % FR; ex = p % HT; ey = p / HT;
         end
         ev = BASE + (ey >> T) * COLS + (ex >> T);
         if (k < LAT + 1) begin
            ehs = 1'b1; evs = 1'b1; eda = 1'b0; els = 1'b0; efs = 1'b0;
         end else begin
            q = (k - LAT - 1) % FR; qx = q % HT; qy = q / HT;
            ehs = !(qx >= W + HF && qx < W + HF + HSY);
            evs = !(qy >= H + VF && qy < H + VF + VSY);
            eda = (qx < W) && (qy < H);
            els = last_en && (qx == 0);
            efs = els && (qy == 0);
         end
         chk("px_x", bus.px_x, ex);
         chk("px_y", bus.px_y, ey);
         chk("vaddr", bus.vaddr, ev);
         chk("vga_HS", bus.vga_HS, ehs);
         chk("vga_VS", bus.vga_VS, evs);
         chk("vga_DA", bus.vga_DA, eda);
         chk("line_start", bus.line_start, els);
         chk("frame_start", bus.frame_start, efs);
         if (bus.px_x == 12'd623 && bus.px_y == 12'd11) begin
            pin_hit++;
            chk("vaddr_623_11", bus.vaddr, 64'h11DB);   // 0x1000 + 2*160 + 155
         end
      end
      cyc++;
      if (bus.vga_DA) da_cnt++;
      if (!bus.vga_VS) vs_low_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (bus.line_start) begin
         ls_cnt++;
         last_gap = cyc - last_ls_cyc;
         last_ls_cyc = cyc;
         if (prev_ls) wide_cnt++;
      end
      prev_ls = bus.line_start;
      if (!bus.vga_HS) begin
         hs_run++;
      end else begin
         if (hs_run != 0) last_hs_run = hs_run;
         hs_run = 0;
      end
   end

   initial begin
      cyc = 0; last_ls_cyc = 0; prev_ls = 1'b0; pin_hit = 0;
      clear_stats();
      bus.en = 1'b0;
      reset  = 1'b1;

      // Reset with en varying; reset must override it.
      step(1'b0, 1'b1);
      check_on = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      @(negedge clk);
      chk("rst_vaddr", bus.vaddr, 64'h1000);
      chk("rst_px_x", bus.px_x, 0);
      chk("rst_hs", bus.vga_HS, 1);
      chk("rst_vs", bus.vga_VS, 1);
      chk("rst_da", bus.vga_DA, 0);
      chk("rst_fs", bus.frame_start, 0);

      // First ticks: (0,0) at tick 1, pins follow two ticks later.
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("t1_px_y", bus.px_y, 0);
      chk("t1_vaddr", bus.vaddr, 64'h1000);
      chk("t1_da", bus.vga_DA, 0);
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("t2_px_x", bus.px_x, 1);
      chk("t2_fs", bus.frame_start, 0);
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("t3_da", bus.vga_DA, 1);
      chk("t3_fs", bus.frame_start, 1);
      chk("t3_ls", bus.line_start, 1);
      #1 clear_stats();

      // One full frame with en held high.
      run(int'(FR), 0);
      @(negedge clk);
      #1;
      chk("frame_da_cycles", da_cnt, 7680);
      chk("frame_line_starts", ls_cnt, 19);
      chk("frame_frame_starts", fs_cnt, 1);
      chk("frame_vs_low_clks", vs_low_cnt, 1600);
      chk("line_period", last_gap, 800);
      chk("hs_low_width", last_hs_run, 96);
      chk("strobe_width", wide_cnt, 0);
      clear_stats();

      // en alternating: everything stretches by two.
      run(4800, 1);
      @(negedge clk);
      #1;
      chk("alt_line_period", last_gap, 1600);
      chk("alt_hs_low_width", last_hs_run, 192);
      chk("alt_line_starts", ls_cnt, 3);
      chk("alt_strobe_width", wide_cnt, 0);

      // Random pixel-tick pattern.
      run(20000, 2);

      // Reset in mid-frame.
      for (int i = 0; i < 20000 && !(bus.px_y >= 12'd5); i++) step(1'b1, 1'b0);
      chk("mid_frame_reached", (bus.px_y >= 12'd5), 1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      @(negedge clk);
      chk("mid_rst_hs", bus.vga_HS, 1);
      chk("mid_rst_vs", bus.vga_VS, 1);
      chk("mid_rst_da", bus.vga_DA, 0);
      chk("mid_rst_px_y", bus.px_y, 0);
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_px_x", bus.px_x, 0);
      chk("post_rst_px_y", bus.px_y, 0);
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_fs_early", bus.frame_start, 0);
      step(1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_fs", bus.frame_start, 1);

      run(500, 2);
      @(negedge clk);
      chk("vaddr_pin_visited", (pin_hit > 0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
